sha_mem_responder: RTL and testbench

- Memory-side responder for the SHA-256/bitcoin hash masters: a single-port word memory that answers the master's mem_we/mem_addr/mem_write_data requests with registered read data.
- Also sequences a hash run:
  - accepts host preload of the message words;
  - issues the start pulse;
  - counts result writes;
  - detects done, or a timeout.
- Sits between the testbench/host and the hash core, in place of the external SRAM.

---
 rtl/sha_mem_responder.sv | 177 +++++++++++++++++
 tb/tb_sha_mem_responder.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha_mem_responder.sv
// sha_mem_responder: single-port word memory standing in for the external SRAM
// of the SHA-256/bitcoin hash masters, plus the run sequencer that preloads,
// launches, counts result writes and detects completion or timeout.
module sha_mem_responder #(
    parameter int DEPTH          = 1024,
    parameter int EXPECT_WRITES  = 16,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        host_we,
    input  logic [15:0] host_addr,
    input  logic [31:0] host_wdata,
    output logic [31:0] host_rdata,
    input  logic        go,
    output logic        start,
    input  logic        done,
    input  logic        mem_we,
    input  logic [15:0] mem_addr,
    input  logic [31:0] mem_write_data,
    output logic [31:0] mem_read_data,
    output logic        busy,
    output logic        complete,
    output logic        timeout,
    output logic [7:0]  wr_count,
    output logic [31:0] cycle_count,
    output logic        addr_err,
    output logic        host_conflict
);

    localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [16:0] DEPTH_L  = 17'(DEPTH);
    localparam logic [31:0] TO_LAST  = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] EXP_WR   = 32'(EXPECT_WRITES);

    typedef enum logic [2:0] {
        IDLE,
        START,
        RUN,
        DONE,
        TOUT
    } state_t;

    state_t      state;
    state_t      next_state;

    logic [31:0] mem [DEPTH];
    logic        done_q;
    logic        core_in_range;
    logic        host_in_range;
    logic        in_run;
    logic        core_wr;
    logic        host_wr;
    logic        launch;
    logic        finish_ok;
    logic        finish_to;

    assign core_in_range = ({1'b0, mem_addr} < DEPTH_L);
    assign host_in_range = ({1'b0, host_addr} < DEPTH_L);
    assign in_run        = (state == RUN);
    assign busy          = (state == START) || (state == RUN);
    assign start         = (state == START);
    assign core_wr       = in_run && mem_we && core_in_range;
    assign host_wr       = !busy && host_we && host_in_range;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and run-event strobes
    always_comb begin
        next_state = state;
        launch     = 1'b0;
        finish_ok  = 1'b0;
        finish_to  = 1'b0;
        case (state)
            IDLE, DONE, TOUT: begin
                if (go) begin
                    next_state = START;
                    launch     = 1'b1;
                end
            end
            START: begin
                next_state = RUN;
            end
            RUN: begin
                // Completion takes precedence over a coincident timeout
                if ((!done_q && done) || (done && (32'(wr_count) >= EXP_WR))) begin
                    next_state = DONE;
                    finish_ok  = 1'b1;
                end else if (cycle_count >= TO_LAST) begin
                    next_state = TOUT;
                    finish_to  = 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Memory array writes; core and host ports are never active together
    always_ff @(posedge clk) begin
        if (core_wr) begin
            mem[mem_addr[AW-1:0]] <= mem_write_data;
        end
        if (host_wr) begin
            mem[host_addr[AW-1:0]] <= host_wdata;
        end
    end

    // Registered read ports (old data on a same-cycle write)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_read_data <= '0;
            host_rdata    <= '0;
        end else begin
            mem_read_data <= core_in_range ? mem[mem_addr[AW-1:0]] : '0;
            host_rdata    <= (!busy && host_in_range) ? mem[host_addr[AW-1:0]] : '0;
        end
    end

    // Registered copy of done for rising-edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_q <= 1'b0;
        end else begin
            done_q <= done;
        end
    end

    // Run counters and status flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_count      <= '0;
            cycle_count   <= '0;
            complete      <= 1'b0;
            timeout       <= 1'b0;
            addr_err      <= 1'b0;
            host_conflict <= 1'b0;
        end else if (launch) begin
            wr_count      <= '0;
            cycle_count   <= '0;
            complete      <= 1'b0;
            timeout       <= 1'b0;
            // an out-of-range access in the launch cycle still counts
            addr_err      <= !core_in_range;
            host_conflict <= 1'b0;
        end else begin
            if (core_wr && (wr_count != '1)) begin
                wr_count <= wr_count + 8'd1;
            end
            // the cycle that leaves RUN is not counted
            if (in_run && !finish_ok && !finish_to && (cycle_count != '1)) begin
                cycle_count <= cycle_count + 32'd1;
            end
            if (finish_ok) begin
                complete <= 1'b1;
            end
            if (finish_to) begin
                timeout <= 1'b1;
            end
            if (!core_in_range) begin
                addr_err <= 1'b1;
            end
            if (busy && host_we) begin
                host_conflict <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sha_mem_responder.sv
// Self-checking bench for sha_mem_responder: table-driven host vectors,
// hand-written run sequences, and randomized traffic against a memory model.
module tb_sha_mem_responder;

    localparam int DEPTH = 1024;
    localparam int EXPW  = 16;
    localparam int TMO   = 50;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        host_we;
    logic [15:0] host_addr;
    logic [31:0] host_wdata;
    logic [31:0] host_rdata;
    logic        go;
    logic        start;
    logic        done;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        busy;
    logic        complete;
    logic        timeout;
    logic [7:0]  wr_count;
    logic [31:0] cycle_count;
    logic        addr_err;
    logic        host_conflict;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] ref_mem [int];

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } hvec_t;

    hvec_t tbl [10];

    always #5 clk = ~clk;

    sha_mem_responder #(
        .DEPTH          (DEPTH),
        .EXPECT_WRITES  (EXPW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .host_we        (host_we),
        .host_addr      (host_addr),
        .host_wdata     (host_wdata),
        .host_rdata     (host_rdata),
        .go             (go),
        .start          (start),
        .done           (done),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data),
        .busy           (busy),
        .complete       (complete),
        .timeout        (timeout),
        .wr_count       (wr_count),
        .cycle_count    (cycle_count),
        .addr_err       (addr_err),
        .host_conflict  (host_conflict)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_read(input logic [15:0] a);
        if (int'(a) >= DEPTH) return 32'h0;
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return 32'h0;
    endfunction

    task automatic ref_write(input logic [15:0] a, input logic [31:0] d);
        if (int'(a) < DEPTH) ref_mem[int'(a)] = d;
    endtask

    task automatic host_write(input logic [15:0] a, input logic [31:0] d);
        host_we    = 1'b1;
        host_addr  = a;
        host_wdata = d;
        tick();
        host_we    = 1'b0;
        ref_write(a, d);
    endtask

    task automatic core_write(input logic [15:0] a, input logic [31:0] d);
        mem_we         = 1'b1;
        mem_addr       = a;
        mem_write_data = d;
        tick();
        mem_we         = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data"}, {host_rdata, mem_read_data}, 64'h0);
        check({tag, "_flags"},
              {start, busy, complete, timeout, addr_err, host_conflict, wr_count, cycle_count},
              64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int          waited;
        bit          seen;
        int          exp_wr;
        bit          any_oor;
        logic        rwe;
        logic [15:0] ra;
        logic [31:0] rd;
        logic [31:0] exp_rd;

        reset_n = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        go = 1'b0; done = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_write_data = '0;

        tbl[0] = '{1'b0, 16'd5,     32'h0,    32'h1005};
        tbl[1] = '{1'b1, 16'd7,     32'h7777, 32'h1007};
        tbl[2] = '{1'b0, 16'd7,     32'h0,    32'h7777};
        tbl[3] = '{1'b0, 16'd1024,  32'h0,    32'h0};
        tbl[4] = '{1'b1, 16'd1024,  32'hFFFF, 32'h0};
        tbl[5] = '{1'b0, 16'd0,     32'h0,    32'h1000};
        tbl[6] = '{1'b0, 16'd19,    32'h0,    32'h1013};
        tbl[7] = '{1'b1, 16'd7,     32'h1007, 32'h7777};
        tbl[8] = '{1'b0, 16'd7,     32'h0,    32'h1007};
        tbl[9] = '{1'b0, 16'hFFFF,  32'h0,    32'h0};

        #12;
        check_all_zero("reset");
        reset_n = 1'b1;
        tick();

        // host preload and readback
        for (int i = 0; i < 20; i++) host_write(16'(i), 32'h1000 + 32'(i));
        host_addr = 16'd5;
        tick();
        check("host_read5", host_rdata, 32'h1005);

        for (int i = 0; i < 10; i++) begin
            host_we    = tbl[i].we;
            host_addr  = tbl[i].addr;
            host_wdata = tbl[i].wdata;
            tick();
            check($sformatf("host_vec%0d", i), host_rdata, tbl[i].exp);
            if (tbl[i].we) ref_write(tbl[i].addr, tbl[i].wdata);
        end
        host_we = 1'b0;
        check("host_no_flags", {addr_err, host_conflict, busy}, 64'h0);

        // run 1: 16 writes then done rises
        go = 1'b1;
        tick();
        check("start_pulse", {start, busy}, 64'h3);
        go = 1'b0;
        tick();
        check("start_one_cycle", {start, busy}, 64'h1);
        for (int i = 0; i < 16; i++) begin
            core_write(16'h100 + 16'(i), 32'hA000 + 32'(i));
            ref_write(16'h100 + 16'(i), 32'hA000 + 32'(i));
        end
        done = 1'b1;
        tick();
        check("run1_complete", {complete, busy, timeout}, 64'h4);
        check("run1_wr_count", wr_count, 64'd16);
        check("run1_cycles", cycle_count, 64'd16);
        tick();
        check("run1_hold", {complete, busy}, 64'h2);
        for (int i = 0; i < 16; i++) begin
            host_addr = 16'h100 + 16'(i);
            tick();
            check("run1_readback", host_rdata, 32'hA000 + 32'(i));
        end

        // run 2: done held high, read-before-write, completion on count
        go = 1'b1;
        tick();
        go = 1'b0;
        tick();
        check("run2_cleared", {complete, wr_count}, 64'h0);
        mem_addr = 16'd3;
        tick();
        check("core_read3", mem_read_data, 32'h1003);
        core_write(16'd3, 32'hDEAD);
        ref_write(16'd3, 32'hDEAD);
        check("core_rbw_old", mem_read_data, 32'h1003);
        tick();
        check("core_rbw_new", mem_read_data, 32'hDEAD);
        check("done_held_no_complete", complete, 64'h0);
        for (int i = 0; i < 15; i++) begin
            core_write(16'h200 + 16'(i), 32'hB000 + 32'(i));
            ref_write(16'h200 + 16'(i), 32'hB000 + 32'(i));
        end
        check("run2_count_reached", {complete, busy, wr_count}, {1'b0, 1'b1, 8'd16});
        tick();
        check("run2_complete", {complete, busy}, 64'h2);

        // run 3: timeout, addr_err, host_conflict
        done = 1'b0;
        mem_addr = '0;
        tick();
        go = 1'b1;
        tick();
        go = 1'b0;
        tick();
        mem_we = 1'b1; mem_addr = 16'(DEPTH); mem_write_data = 32'h1234;
        host_we = 1'b1; host_addr = 16'd5; host_wdata = 32'hBAD0;
        tick();
        mem_we = 1'b0; mem_addr = '0; host_we = 1'b0;
        check("addr_err_set", addr_err, 64'h1);
        check("host_conflict_set", host_conflict, 64'h1);
        check("oor_write_not_counted", wr_count, 64'h0);
        waited = 0;
        seen   = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            tick();
            waited++;
            if (i == 0) check("host_read_busy", host_rdata, 64'h0);
            if (timeout) seen = 1'b1;
        end
        check("timeout_seen", seen, 64'h1);
        check("timeout_latency", waited, 64'd49);
        check("timeout_cycles", cycle_count, 64'd49);
        check("timeout_state", {complete, busy, timeout}, 64'h1);
        tick();
        check("host_conflict_no_write", host_rdata, 32'h1005);

        // randomized host traffic in TOUT
        for (int i = 0; i < 16; i++) host_write(16'h300 + 16'(i), $urandom);
        for (int i = 0; i < 40; i++) begin
            rwe = 1'($urandom_range(0, 1));
            ra  = ($urandom_range(0, 7) == 0) ? 16'(DEPTH + int'($urandom_range(0, 100)))
                                             : 16'h300 + 16'($urandom_range(0, 15));
            rd  = $urandom;
            exp_rd = ref_read(ra);
            host_we = rwe; host_addr = ra; host_wdata = rd;
            tick();
            check("rand_host_read", host_rdata, exp_rd);
            if (rwe) ref_write(ra, rd);
        end
        host_we = 1'b0;

        // run 4: relaunch clears flags, randomized core traffic
        go = 1'b1;
        tick();
        go = 1'b0;
        check("relaunch_cleared",
              {complete, timeout, addr_err, host_conflict, wr_count, cycle_count}, 64'h0);
        tick();
        exp_wr  = 0;
        any_oor = 1'b0;
        for (int i = 0; i < 30; i++) begin
            rwe = 1'($urandom_range(0, 1));
            ra  = ($urandom_range(0, 9) == 0) ? 16'(DEPTH + int'($urandom_range(0, 500)))
                                             : 16'h300 + 16'($urandom_range(0, 15));
            rd  = $urandom;
            exp_rd = ref_read(ra);
            mem_we = rwe; mem_addr = ra; mem_write_data = rd;
            tick();
            check("rand_core_read", mem_read_data, exp_rd);
            if (int'(ra) >= DEPTH) any_oor = 1'b1;
            else if (rwe) begin
                ref_write(ra, rd);
                exp_wr++;
            end
        end
        mem_we = 1'b0; mem_addr = '0;
        done = 1'b1;
        tick();
        check("rand_complete", {complete, timeout, busy}, 64'h4);
        check("rand_wr_count", wr_count, 64'(exp_wr));
        check("rand_addr_err", addr_err, 64'(any_oor));
        check("rand_cycles", cycle_count, 64'd30);
        for (int i = 0; i < 16; i++) begin
            host_addr = 16'h300 + 16'(i);
            tick();
            check("rand_readback", host_rdata, ref_read(16'h300 + 16'(i)));
        end

        // run 5: reset mid-run keeps memory
        done = 1'b0;
        tick();
        go = 1'b1;
        tick();
        go = 1'b0;
        tick();
        core_write(16'h3F0, 32'h5A5A);
        check("pre_reset_busy", {busy, wr_count}, {1'b1, 8'd1});
        reset_n = 1'b0;
        #2;
        check_all_zero("midrun_reset");
        #2;
        reset_n = 1'b1;
        tick();
        host_addr = 16'h3F0;
        tick();
        check("mem_kept_after_reset", host_rdata, 32'h5A5A);
        host_addr = 16'd5;
        tick();
        check("mem_kept_preload", host_rdata, 32'h1005);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
